mul_issue_ctrl: RTL and testbench

Sequences the backend's shared signed 32x32 pipelined multiplier for RV32M MUL/MULH/MULHSU/MULHU. The multiplier has 3-cycle fixed latency and cannot stall. This block accepts ops from issue over valid/ready and drives the multiplier one op per cycle. It applies unsigned high-word correction and buffers results in a credited in-order FIFO so writeback backpressure never loses a result. It also supports pipeline flush.

---
 rtl/mul_issue_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue-side sequencer for the shared 3-cycle signed 32x32
// multiplier. Accepts one RV32M multiply per cycle, carries a sideband pipe
// aligned with the multiplier, applies the unsigned high-word correction and
// buffers results in a credited in-order FIFO so writeback can stall freely.
module mul_issue_ctrl #(
  parameter int TAG_W        = 5,
  parameter int RESULT_DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             mul_en,
  output logic [31:0]      mul_rs1,
  output logic [31:0]      mul_rs2,
  input  logic [31:0]      mul_lo,
  input  logic [31:0]      mul_hi,
  input  logic             mul_valid,
  output logic             busy
);

  localparam int STAGES = 3;
  localparam int PTR_W  = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RESULT_DEPTH + 1);

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  // Sideband carried next to each op while the multiplier works on it.
  typedef struct packed {
    logic             killed;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
    logic [31:0]      a;
    logic [31:0]      b;
  } sb_t;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } res_t;

  // Stage 0 is the accept itself (combinational); stages 1..3 are registers.
  logic [STAGES:1]  vld_q;
  logic [STAGES:0]  vld_pipe;
  sb_t              sb_s0;
  sb_t              sb_q [STAGES:1];
  sb_t              sb_d [STAGES:1];
  sb_t              s3;

  logic [CNT_W-1:0] inflight_cnt;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W:0]   credit_used;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  res_t             mem [RESULT_DEPTH];
  res_t             head;

  logic             accept, push, pop;
  logic [31:0]      res_data;
  logic [1:0]       arm_cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESULT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits cover every op from accept until its result is popped, so a
  // stage-3 result always has a FIFO slot waiting for it.
  assign credit_used = {1'b0, inflight_cnt} + {1'b0, fifo_cnt};
  assign req_ready   = !rst && !flush && (credit_used < (CNT_W+1)'(RESULT_DEPTH));
  assign accept      = req_valid && req_ready;

  assign mul_en  = accept;
  assign mul_rs1 = req_rs1;
  assign mul_rs2 = req_rs2;

  assign vld_pipe = {vld_q, accept};
  assign s3       = sb_q[STAGES];

  // Stage-0 sideband built straight from the request.
  always_comb begin
    sb_s0        = '0;
    sb_s0.killed = 1'b0;
    sb_s0.op     = req_op;
    sb_s0.tag    = req_tag;
    sb_s0.a      = req_rs1;
    sb_s0.b      = req_rs2;
  end

  // Next sideband stages: shift by one, flush marks everything killed.
  always_comb begin
    sb_d[1]        = sb_s0;
    sb_d[1].killed = sb_s0.killed | flush;
    for (int i = 2; i <= STAGES; i++) begin
      sb_d[i]        = sb_q[i-1];
      sb_d[i].killed = sb_q[i-1].killed | flush;
    end
  end

  // Valid shift register; the only sideband state that needs reset.
  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_pipe[STAGES-1:0];
  end

  // Sideband payload, meaningful only where the matching valid is set.
  always_ff @(posedge clk) begin
    sb_q <= sb_d;
  end

  // Multiplier returns the signed high word; fold in the operand terms that
  // turn it into the signed*unsigned or unsigned*unsigned high word.
  always_comb begin
    res_data = mul_lo;
    case (op_e'(s3.op))
      OP_MUL:    res_data = mul_lo;
      OP_MULH:   res_data = mul_hi;
      OP_MULHSU: res_data = mul_hi + (s3.b[31] ? s3.a : 32'd0);
      OP_MULHU:  res_data = mul_hi + (s3.a[31] ? s3.b : 32'd0)
                                   + (s3.b[31] ? s3.a : 32'd0);
      default:   res_data = mul_lo;
    endcase
  end

  // A flush in the same cycle drops the stage-3 result instead of pushing it.
  assign push = vld_q[STAGES] && !s3.killed && !flush;
  assign pop  = resp_valid && resp_ready;

  // In-flight count: killed ops keep their credit until they leave stage 3.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_cnt <= '0;
    end else begin
      case ({accept, vld_q[STAGES]})
        2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
        2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

  // FIFO control: pointers and occupancy; flush empties it in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage; contents need no reset since the outputs are gated.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: res_data, tag: s3.tag};
  end

  assign head       = mem[rd_ptr];
  assign resp_valid = (fifo_cnt != '0);
  assign resp_data  = resp_valid ? head.data : 32'd0;
  assign resp_tag   = resp_valid ? head.tag  : '0;
  assign busy       = (inflight_cnt != '0) || (fifo_cnt != '0);

  // Counts cycles since reset release; the multiplier's own valid stages
  // are unreset, so its mul_valid is only trusted once this saturates.
  always_ff @(posedge clk) begin
    if (rst)                  arm_cnt <= 2'd0;
    else if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
  end

  a_mul_valid_align: assert property (@(posedge clk)
    (!rst && arm_cnt == 2'd3) |-> (vld_q[STAGES] == mul_valid));

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && fifo_cnt == CNT_W'(RESULT_DEPTH)));

  a_fifo_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && fifo_cnt == '0));

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural 3-cycle signed
// multiplier whose valid pipe is deliberately left unreset.
module tb_mul_issue_ctrl;

  localparam int TAG_W = 5;
  localparam int DEPTH = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_rs1, req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             mul_en;
  logic [31:0]      mul_rs1, mul_rs2;
  logic [31:0]      mul_lo, mul_hi;
  logic             mul_valid;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] q_data[$];
  logic [31:0] q_tag[$];
  int          q_cyc[$];

  mul_issue_ctrl #(.TAG_W(TAG_W), .RESULT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag),
    .mul_en(mul_en), .mul_rs1(mul_rs1), .mul_rs2(mul_rs2),
    .mul_lo(mul_lo), .mul_hi(mul_hi), .mul_valid(mul_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Signed multiplier model, 3 cycles from capture to output.
  logic [63:0] p1, p2, p3;
  logic        v1, v2, v3;
  always @(posedge clk) begin
    v1 <= mul_en;
    v2 <= v1;
    v3 <= v2;
    if (mul_en)
      p1 <= $signed({{32{mul_rs1[31]}}, mul_rs1}) * $signed({{32{mul_rs2[31]}}, mul_rs2});
    p2 <= p1;
    p3 <= p2;
  end
  assign mul_lo    = p3[31:0];
  assign mul_hi    = p3[63:32];
  assign mul_valid = v3;

  always @(posedge clk) cyc <= cyc + 1;

  // Response logger: records every handshake with the cycle it happened in.
  always @(negedge clk) begin
    if (resp_valid && resp_ready) begin
      q_data.push_back(resp_data);
      q_tag.push_back(32'(resp_tag));
      q_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAG_W-1:0] tag);
    req_valid = v;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_tag   = tag;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_tag.delete();
    q_cyc.delete();
  endtask

  logic [1:0]  t2_op  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
  logic [31:0] t2_a   [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
  logic [31:0] t2_b   [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002};
  logic [31:0] t2_exp [5] = '{32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};

  initial begin
    int c0, p, acc, tg;

    // Reset, with a request held up to see that nothing is accepted.
    rst = 1'b1; flush = 1'b0; resp_ready = 1'b1;
    drive(1'b1, 2'd0, 32'd1, 32'd1, 5'd0);
    repeat (3) tick();
    settle();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mul_en",    32'(mul_en),    32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
    settle();
    chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("post_rst_resp_data",  resp_data,       32'd0);
    chk("post_rst_resp_tag",   32'(resp_tag),   32'd0);
    chk("post_rst_busy",       32'(busy),       32'd0);
    chk("post_rst_req_ready",  32'(req_ready),  32'd1);

    // Single MUL 7 * -3: response four cycles after accept.
    tick();
    drive(1'b1, 2'd0, 32'd7, 32'hFFFFFFFD, 5'd3);
    settle();
    chk("t1_accept", 32'(mul_en),  32'd1);
    chk("t1_rs1",    mul_rs1,      32'd7);
    tick();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
    settle();
    chk("t1_busy_c1",  32'(busy),       32'd1);
    chk("t1_rv_c1",    32'(resp_valid), 32'd0);
    tick(); tick(); settle();
    chk("t1_rv_c3",    32'(resp_valid), 32'd0);
    tick(); settle();
    chk("t1_rv_c4",    32'(resp_valid), 32'd1);
    chk("t1_data",     resp_data,       32'hFFFFFFEB);
    chk("t1_tag",      32'(resp_tag),   32'd3);
    tick(); settle();
    chk("t1_rv_c5",    32'(resp_valid), 32'd0);
    chk("t1_busy_c5",  32'(busy),       32'd0);

    // Four op kinds on all-ones operands, then MULHU 0x80000000 * 2.
    clear_q();
    c0 = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(1'b1, t2_op[i], t2_a[i], t2_b[i], 5'(10 + i));
      settle();
      if (i == 0) c0 = cyc;
      chk("t2_ready", 32'(req_ready), 32'd1);
    end
    tick();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
    repeat (6) tick();
    chk("t2_count", 32'(q_data.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < q_data.size()) begin
        chk("t2_data", q_data[i], t2_exp[i]);
        chk("t2_tag",  q_tag[i],  32'(10 + i));
        chk("t2_cyc",  32'(q_cyc[i]), 32'(c0 + 4 + i));
      end
    end

    // Eight back-to-back MULs: full throughput, consecutive in-order responses.
    clear_q();
    for (int i = 0; i < 8; i++) begin
      tick();
      drive(1'b1, 2'd0, 32'(i + 1), 32'd3, 5'(16 + i));
      settle();
      if (i == 0) c0 = cyc;
      chk("t3_ready", 32'(req_ready), 32'd1);
    end
    tick();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
    repeat (8) tick();
    chk("t3_count", 32'(q_data.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < q_data.size()) begin
        chk("t3_data", q_data[i], 32'(3 * (i + 1)));
        chk("t3_tag",  q_tag[i],  32'(16 + i));
        chk("t3_cyc",  32'(q_cyc[i]), 32'(c0 + 4 + i));
      end
    end

    // Writeback stalled: credits cap accepts at the FIFO depth.
    clear_q();
    resp_ready = 1'b0;
    acc = 0;
    tg  = 20;
    for (int i = 0; i < 10; i++) begin
      tick();
      drive(1'b1, 2'd0, 32'(tg), 32'd1, 5'(tg));
      settle();
      if (req_ready) begin
        acc++;
        tg++;
      end
    end
    chk("t4_accepts",    32'(acc),        32'd5);
    chk("t4_ready_full", 32'(req_ready),  32'd0);
    chk("t4_rv_full",    32'(resp_valid), 32'd1);
    chk("t4_head_hold",  resp_data,       32'd20);
    tick();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
    resp_ready = 1'b1;
    settle();
    p = cyc;
    chk("t4_ready_pop_cycle",  32'(req_ready), 32'd0);
    tick(); settle();
    chk("t4_ready_after_pop",  32'(req_ready), 32'd1);
    repeat (5) tick();
    chk("t4_count", 32'(q_data.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < q_data.size()) begin
        chk("t4_data", q_data[i], 32'(20 + i));
        chk("t4_tag",  q_tag[i],  32'(20 + i));
        chk("t4_cyc",  32'(q_cyc[i]), 32'(p + i));
      end
    end

    // Flush with two results buffered and three in flight.
    settle();
    chk("t5_idle_busy", 32'(busy), 32'd0);
    clear_q();
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(1'b1, 2'd0, 32'(i + 2), 32'd3, 5'(24 + i));
      settle();
    end
    tick();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
    flush = 1'b1;
    settle();
    chk("t5_F_ready",  32'(req_ready),  32'd0);
    chk("t5_F_rv",     32'(resp_valid), 32'd1);
    chk("t5_F_busy",   32'(busy),       32'd1);
    tick();
    flush = 1'b0;
    resp_ready = 1'b1;
    settle();
    chk("t5_F1_rv",    32'(resp_valid), 32'd0);
    chk("t5_F1_busy",  32'(busy),       32'd1);
    tick(); settle();
    tick(); settle();
    chk("t5_F3_busy",  32'(busy),       32'd0);
    chk("t5_F3_ready", 32'(req_ready),  32'd1);
    drive(1'b1, 2'd0, 32'd6, 32'd7, 5'd9);
    settle();
    p = cyc;
    chk("t5_new_accept", 32'(mul_en), 32'd1);
    tick();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
    repeat (6) tick();
    chk("t5_count", 32'(q_data.size()), 32'd1);
    if (q_data.size() > 0) begin
      chk("t5_data", q_data[0], 32'd42);
      chk("t5_tag",  q_tag[0],  32'd9);
      chk("t5_cyc",  32'(q_cyc[0]), 32'(p + 4));
    end

    // Reset with two ops in flight: they never come back.
    clear_q();
    tick();
    drive(1'b1, 2'd0, 32'd5, 32'd5, 5'd1);
    settle();
    tick();
    drive(1'b1, 2'd0, 32'd6, 32'd6, 5'd2);
    settle();
    tick();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
    rst = 1'b1;
    settle();
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    tick(); settle();
    chk("t6_rv",    32'(resp_valid), 32'd0);
    chk("t6_data",  resp_data,       32'd0);
    chk("t6_tag",   32'(resp_tag),   32'd0);
    chk("t6_busy",  32'(busy),       32'd0);
    chk("t6_ready", 32'(req_ready),  32'd0);
    chk("t6_mul_en", 32'(mul_en),    32'd0);
    tick();
    rst = 1'b0;
    settle();
    for (int i = 0; i < 10; i++) begin
      chk("t6_no_resp", 32'(resp_valid), 32'd0);
      tick();
    end
    chk("t6_count", 32'(q_data.size()), 32'd0);
    chk("t6_busy_end", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
